// File: rtl/lookahead_carry_adder.sv
// rtl/lookahead_carry_adder.sv - two-level carry-lookahead adder with registered result
// 4-bit lookahead groups feed a second-level unit that forms every group carry in parallel.
module lookahead_carry_adder #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             out_valid,
    output logic             grp_p,
    output logic             grp_g
);
    localparam int NG = WIDTH / 4;

    generate
        if (WIDTH <= 0 || (WIDTH % 4) != 0) begin : g_bad_width
            $fatal(1, "lookahead_carry_adder: WIDTH must be a positive multiple of 4");
        end
    endgenerate

    // Flat sum-of-products carry into group k: no term depends on another group's carry.
    function automatic logic group_carry(input logic [NG-1:0] gp, input logic [NG-1:0] gg,
                                         input logic cin, input int k);
        logic res;
        logic prod;
        res = 1'b0;
        for (int j = 0; j < k; j++) begin
            prod = gg[j];
            for (int m = j + 1; m < k; m++) prod = prod & gp[m];
            res = res | prod;
        end
        prod = cin;
        for (int m = 0; m < k; m++) prod = prod & gp[m];
        return res | prod;
    endfunction

    logic [WIDTH-1:0] w_p;
    logic [WIDTH-1:0] w_g;
    logic [WIDTH-1:0] w_c;
    logic [WIDTH-1:0] w_sum;
    logic [NG-1:0]    w_gp;
    logic [NG-1:0]    w_gg;
    logic [NG:0]      w_gc;
    logic             w_word_g;

    assign w_p = a ^ b;
    assign w_g = a & b;

    genvar k;
    generate
        for (k = 0; k < NG; k++) begin : g_grp
            logic [3:0] w_bp;
            logic [3:0] w_bg;
            logic       w_c0;
            assign w_bp = w_p[4*k +: 4];
            assign w_bg = w_g[4*k +: 4];
            assign w_c0 = w_gc[k];

            assign w_c[4*k]     = w_c0;
            assign w_c[4*k + 1] = w_bg[0] | (w_bp[0] & w_c0);
            assign w_c[4*k + 2] = w_bg[1] | (w_bp[1] & w_bg[0]) | (w_bp[1] & w_bp[0] & w_c0);
            assign w_c[4*k + 3] = w_bg[2] | (w_bp[2] & w_bg[1]) | (w_bp[2] & w_bp[1] & w_bg[0])
                                | (w_bp[2] & w_bp[1] & w_bp[0] & w_c0);

            assign w_gp[k] = &w_bp;
            assign w_gg[k] = w_bg[3] | (w_bp[3] & w_bg[2]) | (w_bp[3] & w_bp[2] & w_bg[1])
                           | (w_bp[3] & w_bp[2] & w_bp[1] & w_bg[0]);

            assign w_gc[k + 1] = group_carry(w_gp, w_gg, c_in, k + 1);
        end
    endgenerate

    assign w_gc[0]  = c_in;
    assign w_sum    = w_p ^ w_c;
    assign w_word_g = group_carry(w_gp, w_gg, 1'b0, NG);

    logic [WIDTH-1:0] r_sum;
    logic             r_c_out;
    logic             r_out_valid;
    logic             r_grp_p;
    logic             r_grp_g;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sum       <= '0;
            r_c_out     <= 1'b0;
            r_out_valid <= 1'b0;
            r_grp_p     <= 1'b0;
            r_grp_g     <= 1'b0;
        end else begin
            r_out_valid <= in_valid;
            if (in_valid) begin
                r_sum   <= w_sum;
                r_c_out <= w_gc[NG];
                r_grp_p <= &w_gp;
                r_grp_g <= w_word_g;
            end
        end
    end

    assign sum       = r_sum;
    assign c_out     = r_c_out;
    assign out_valid = r_out_valid;
    assign grp_p     = r_grp_p;
    assign grp_g     = r_grp_g;
endmodule

// File: tb/tb_lookahead_carry_adder.sv
// tb/tb_lookahead_carry_adder.sv - directed bench for lookahead_carry_adder
// Drives a 4-bit and a 16-bit instance from one sequence of steps.
module tb_lookahead_carry_adder;
    logic        clk = 1'b0;
    logic        rst;
    logic        v4, v16;
    logic [3:0]  a4, b4;
    logic [15:0] a16, b16;
    logic        ci4, ci16;
    logic [3:0]  s4;
    logic [15:0] s16;
    logic        co4, co16, ov4, ov16, gp4, gp16, gg4, gg16;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    lookahead_carry_adder #(.WIDTH(4)) u4 (
        .clk(clk), .rst(rst), .in_valid(v4), .a(a4), .b(b4), .c_in(ci4),
        .sum(s4), .c_out(co4), .out_valid(ov4), .grp_p(gp4), .grp_g(gg4));

    lookahead_carry_adder #(.WIDTH(16)) u16 (
        .clk(clk), .rst(rst), .in_valid(v16), .a(a16), .b(b16), .c_in(ci16),
        .sum(s16), .c_out(co16), .out_valid(ov16), .grp_p(gp16), .grp_g(gg16));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic op4(input logic [3:0] a, input logic [3:0] b, input logic c, input logic v);
        @(negedge clk);
        a4 = a; b4 = b; ci4 = c; v4 = v;
        @(posedge clk);
        #1;
    endtask

    logic [4:0] exp5;

    initial begin
        rst = 1'b1; v4 = 1'b1; a4 = 4'hF; b4 = 4'hF; ci4 = 1'b1;
        v16 = 1'b1; a16 = 16'hFFFF; b16 = 16'hFFFF; ci16 = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            check("rst_sum", {28'd0, s4}, 32'h0);
            check("rst_cout", {31'd0, co4}, 32'h0);
            check("rst_ovalid", {31'd0, ov4}, 32'h0);
            check("rst_grp", {30'd0, gp4, gg4}, 32'h0);
        end
        @(negedge clk);
        rst = 1'b0; v16 = 1'b0;

        op4(4'h0, 4'h0, 1'b0, 1'b1);
        check("zero_sum", {27'd0, co4, s4}, 32'h00);
        check("zero_ovalid", {31'd0, ov4}, 32'h1);
        op4(4'hF, 4'h1, 1'b0, 1'b1);
        check("wrap_sum", {27'd0, co4, s4}, 32'h10);
        op4(4'hF, 4'hF, 1'b1, 1'b1);
        check("max_sum", {27'd0, co4, s4}, 32'h1F);
        check("max_grp", {30'd0, gp4, gg4}, 32'h1);
        op4(4'h5, 4'hA, 1'b1, 1'b1);
        check("prop_sum", {27'd0, co4, s4}, 32'h10);
        check("prop_grp", {30'd0, gp4, gg4}, 32'h2);
        op4(4'h0, 4'h0, 1'b1, 1'b1);
        check("cin_only", {27'd0, co4, s4}, 32'h01);
        op4(4'hF, 4'h0, 1'b1, 1'b1);
        check("fullprop_sum", {27'd0, co4, s4}, 32'h10);
        check("fullprop_grp", {30'd0, gp4, gg4}, 32'h2);

        op4(4'h3, 4'h4, 1'b0, 1'b1);
        check("hold_load", {27'd0, co4, s4}, 32'h07);
        op4(4'hF, 4'hF, 1'b0, 1'b0);
        check("hold_sum", {27'd0, co4, s4}, 32'h07);
        check("hold_ovalid", {31'd0, ov4}, 32'h0);
        check("hold_grp", {30'd0, gp4, gg4}, 32'h0);

        // Operation presented together with reset must vanish.
        @(negedge clk);
        a4 = 4'h9; b4 = 4'h9; ci4 = 1'b0; v4 = 1'b1; rst = 1'b1;
        @(posedge clk); #1;
        op4(4'h9, 4'h9, 1'b0, 1'b0);
        rst = 1'b0;
        op4(4'h9, 4'h9, 1'b0, 1'b0);
        check("midrst_sum", {27'd0, co4, s4}, 32'h00);
        check("midrst_ovalid", {31'd0, ov4}, 32'h0);

        for (int i = 0; i < 50; i++) begin
            logic [3:0] ra, rb;
            logic       rc;
            ra = 4'($urandom_range(15)); rb = 4'($urandom_range(15)); rc = 1'($urandom_range(1));
            exp5 = {1'b0, ra} + {1'b0, rb} + {4'd0, rc};
            op4(ra, rb, rc, 1'b1);
            check("rand_sum", {27'd0, co4, s4}, {27'd0, exp5});
            check("rand_ovalid", {31'd0, ov4}, 32'h1);
        end

        for (int i = 0; i < 512; i++) begin
            logic [8:0] vec;
            vec  = 9'(i);
            exp5 = {1'b0, vec[8:5]} + {1'b0, vec[4:1]} + {4'd0, vec[0]};
            op4(vec[8:5], vec[4:1], vec[0], 1'b1);
            check("exh_sum", {27'd0, co4, s4}, {27'd0, exp5});
        end
        v4 = 1'b0;

        @(negedge clk);
        a16 = 16'hFFFF; b16 = 16'h0000; ci16 = 1'b1; v16 = 1'b1;
        @(posedge clk); #1;
        check("w16_prop_sum", {15'd0, co16, s16}, 32'h10000);
        check("w16_prop_grp", {30'd0, gp16, gg16}, 32'h2);
        @(negedge clk);
        a16 = 16'h00FF; b16 = 16'h0001; ci16 = 1'b0;
        @(posedge clk); #1;
        check("w16_byte_sum", {15'd0, co16, s16}, 32'h00100);
        @(negedge clk);
        a16 = 16'h8000; b16 = 16'h8000; ci16 = 1'b0;
        @(posedge clk); #1;
        check("w16_gen_sum", {15'd0, co16, s16}, 32'h10000);
        check("w16_gen_grp", {30'd0, gp16, gg16}, 32'h1);
        v16 = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
